// File: rtl/usr_param_if.sv
// Bus interface for usr_param: control, serial/parallel data and status.
// Optional parity output appears only when USR_PARITY_EN is defined.
interface usr_param_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic             rot;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] pin;
    logic             start;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pout;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;
`ifdef USR_PARITY_EN
    logic             parity;
`endif

    // Driver side: issues operations, observes register and burst status
    modport master (
        output en, mode, rot, sin_l, sin_r, pin, start, cnt,
`ifdef USR_PARITY_EN
        input  parity,
`endif
        input  pout, sout_l, sout_r, busy, done
    );

    // Register side
    modport slave (
        input  en, mode, rot, sin_l, sin_r, pin, start, cnt,
`ifdef USR_PARITY_EN
        output parity,
`endif
        output pout, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/usr_param.sv
// Parametrised universal shift register with hold / shift-left / shift-right /
// parallel load, optional rotate, and an autonomous burst engine that performs
// a programmed number of shift or rotate steps.
// Optional feature macro: USR_PARITY_EN (adds parity = ^pout).
module usr_param #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    usr_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pout_q;
    logic [CW-1:0]    cnt_q;
    logic             left_q;
    logic             rot_q;
    logic             busy_q;
    logic             done_q;

    mode_e            mode_ext;
    logic             is_shift_mode;
    logic             step_left_d;
    logic             step_rot_d;
    logic [WIDTH-1:0] shl_d;
    logic [WIDTH-1:0] shr_d;
    logic [WIDTH-1:0] step_d;

    // One-step shift result; a burst uses its captured direction/rotate,
    // manual ops use the live inputs. Serial inputs are always live.
    always_comb begin
        mode_ext      = mode_e'(bus.mode);
        is_shift_mode = (mode_ext == MODE_SHL) || (mode_ext == MODE_SHR);
        step_left_d   = (state_q == ST_RUN) ? left_q : (mode_ext == MODE_SHL);
        step_rot_d    = (state_q == ST_RUN) ? rot_q  : bus.rot;
        shl_d         = {pout_q[WIDTH-2:0], step_rot_d ? pout_q[WIDTH-1] : bus.sin_l};
        shr_d         = {step_rot_d ? pout_q[0] : bus.sin_r, pout_q[WIDTH-1:1]};
        step_d        = step_left_d ? shl_d : shr_d;
    end

    // Control FSM with register update, burst counter and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pout_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            rot_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // start is only meaningful for shift modes; for hold/load it
                    // is ignored and the manual op proceeds as usual
                    if (bus.start && is_shift_mode) begin
                        if (bus.cnt == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            left_q  <= (mode_ext == MODE_SHL);
                            rot_q   <= bus.rot;
                            cnt_q   <= bus.cnt;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end
                    end else if (bus.en) begin
                        unique case (mode_ext)
                            MODE_SHL,
                            MODE_SHR:  pout_q <= step_d;
                            MODE_LOAD: pout_q <= bus.pin;
                            default:   pout_q <= pout_q;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (bus.en) begin
                        pout_q <= step_d;
                        cnt_q  <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pout   = pout_q;
    assign bus.sout_l = pout_q[WIDTH-1];
    assign bus.sout_r = pout_q[0];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

`ifdef USR_PARITY_EN
    assign bus.parity = ^pout_q;
`endif

endmodule

// File: tb/tb_usr_param.sv
// Directed self-checking bench for usr_param (WIDTH=8).
// Parity checks are compiled in when USR_PARITY_EN is defined.
module tb_usr_param;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst;

    usr_param_if #(.WIDTH(WIDTH)) bus ();

    usr_param #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.en    = 1'b1;
        bus.mode  = 2'b00;
        bus.rot   = 1'b0;
        bus.sin_l = 1'b0;
        bus.sin_r = 1'b0;
        bus.pin   = '0;
        bus.start = 1'b0;
        bus.cnt   = '0;
    endtask

    task automatic load(input logic [7:0] v);
        bus.en    = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'b11;
        bus.pin   = v;
        tick();
        bus.mode  = 2'b00;
    endtask

    task automatic start_burst(input logic [1:0] m, input logic r, input logic [CW-1:0] c);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.rot   = r;
        bus.cnt   = c;
        tick();
        bus.start = 1'b0;
        bus.mode  = 2'b11;
        bus.pin   = 8'hFF;
        bus.rot   = 1'b0;
        bus.cnt   = '0;
    endtask

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_pout", bus.pout, 32'h00);
        check("rst_busy", bus.busy, 32'h0);
        check("rst_done", bus.done, 32'h0);
`ifdef USR_PARITY_EN
        check("rst_par", bus.parity, 32'h0);
`endif

        // Parallel load
        load(8'hA5);
        check("load_pout", bus.pout, 32'hA5);
        check("load_soutl", bus.sout_l, 32'h1);
        check("load_soutr", bus.sout_r, 32'h1);
`ifdef USR_PARITY_EN
        check("par_A5", bus.parity, 32'h0);
`endif

        // Fill shift left with sin_l=1
        bus.mode = 2'b01; bus.rot = 1'b0; bus.sin_l = 1'b1;
        tick();
        check("shl_fill", bus.pout, 32'h4B);
`ifdef USR_PARITY_EN
        check("par_4B", bus.parity, 32'h0);
`endif

        // Rotate right
        load(8'hA5);
        bus.mode = 2'b10; bus.rot = 1'b1;
        tick();
        check("shr_rot", bus.pout, 32'hD2);
`ifdef USR_PARITY_EN
        check("par_D2", bus.parity, 32'h0);
`endif

        // Hold, then en=0 blocks a shift
        bus.mode = 2'b00; bus.rot = 1'b0;
        tick();
        check("hold", bus.pout, 32'hD2);
        bus.mode = 2'b01; bus.en = 1'b0;
        tick();
        check("en_low", bus.pout, 32'hD2);
        bus.en = 1'b1;

        // Fill shift right with sin_r=0
        bus.mode = 2'b10; bus.sin_r = 1'b0;
        tick();
        check("shr_fill", bus.pout, 32'h69);
        quiet();

        // Burst: rotate left 3 steps from 81
        load(8'h81);
        start_burst(2'b01, 1'b1, CW'(3));
        check("b_start_busy", bus.busy, 32'h1);
        check("b_start_pout", bus.pout, 32'h81);
        check("b_start_done", bus.done, 32'h0);
        tick();
        check("b_s1", bus.pout, 32'h03);
        check("b_s1_busy", bus.busy, 32'h1);
        tick();
        check("b_s2", bus.pout, 32'h06);
        check("b_s2_done", bus.done, 32'h0);
        tick();
        check("b_s3", bus.pout, 32'h0C);
        check("b_s3_busy", bus.busy, 32'h0);
        check("b_s3_done", bus.done, 32'h1);
        bus.mode = 2'b00;
        tick();
        check("b_done_pulse", bus.done, 32'h0);
        check("b_after", bus.pout, 32'h0C);

        // Burst with 2-cycle stall
        load(8'h81);
        start_burst(2'b01, 1'b1, CW'(3));
        tick();
        check("st_s1", bus.pout, 32'h03);
        bus.en = 1'b0;
        tick();
        tick();
        check("st_hold", bus.pout, 32'h03);
        check("st_busy", bus.busy, 32'h1);
        check("st_done", bus.done, 32'h0);
        bus.en = 1'b1;
        tick();
        check("st_s2", bus.pout, 32'h06);
        check("st_s2_busy", bus.busy, 32'h1);
        tick();
        check("st_s3", bus.pout, 32'h0C);
        check("st_s3_done", bus.done, 32'h1);
        bus.mode = 2'b00;

        // cnt=0 start
        start_burst(2'b01, 1'b1, CW'(0));
        check("c0_done", bus.done, 32'h1);
        check("c0_busy", bus.busy, 32'h0);
        check("c0_pout", bus.pout, 32'h0C);
        bus.mode = 2'b00;
        tick();
        check("c0_pulse", bus.done, 32'h0);

        // Reset mid-burst
        load(8'h81);
        start_burst(2'b01, 1'b1, CW'(3));
        tick();
        check("rm_s1", bus.pout, 32'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mode = 2'b00;
        check("rm_pout", bus.pout, 32'h00);
        check("rm_busy", bus.busy, 32'h0);
        check("rm_done0", bus.done, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rm_no_done", bus.done, 32'h0);
        end

        // Start while busy is ignored
        load(8'h81);
        start_burst(2'b01, 1'b1, CW'(2));
        bus.start = 1'b1; bus.mode = 2'b10; bus.cnt = CW'(5);
        tick();
        check("sb_s1", bus.pout, 32'h03);
        tick();
        check("sb_s2", bus.pout, 32'h06);
        check("sb_done", bus.done, 32'h1);
        check("sb_busy", bus.busy, 32'h0);
        quiet();
        tick();
        check("sb_idle_busy", bus.busy, 32'h0);
        check("sb_idle_pout", bus.pout, 32'h06);

        // cnt > WIDTH fill burst flushes with sin_r
        load(8'h00);
        bus.sin_r = 1'b1;
        start_burst(2'b10, 1'b0, CW'(9));
        tick();
        check("fl_s1", bus.pout, 32'h80);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("fl_busy", bus.busy, 32'h1);
        end
        tick();
        check("fl_pout", bus.pout, 32'hFF);
        check("fl_done", bus.done, 32'h1);
        check("fl_busy_end", bus.busy, 32'h0);
        quiet();

`ifdef USR_PARITY_EN
        load(8'h07);
        check("par_07", bus.parity, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
